conv_seq_ctrl: RTL and testbench
================================

Name: conv_seq_ctrl

Overview:
Run controller for one convolutional layer pass of conv_blk. On a start request it resets conv_blk, raises go, and writes each conv_blk result (o_en/o_conv_result) into the output feature-map BRAM at sequential addresses. It counts results to completion, then pulses done. It flags an error if the datapath stalls beyond a timeout.

Parameters:
KERNEL_SIZE, 3, kernel edge length
FM_SIZE, 6, input feature-map edge length
PADDING, 0, zero padding per side
STRIDE, 1, convolution stride
MAXPOOL, 1, 1 = conv_blk emits 2x2-pooled results, 0 = raw results
DATA_WIDTH, 48, result/BRAM word width
CLR_CYCLES, 2, cycles conv_blk reset is held at run start (>=1)
TIMEOUT, 1024, max cycles without i_en while running
(local) OUT_SIZE = ((FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE)+1
(local) N_RES = MAXPOOL ? (OUT_SIZE/2)**2 : OUT_SIZE**2
(local) AW = max(1,$clog2(N_RES))

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-low
i_start  in  1  run request, sampled in IDLE only
i_abort  in  1  abandon current run
o_blk_rst  out  1  active-high reset to conv_blk
o_go  out  1  go to conv_blk
i_en  in  1  conv_blk result valid
i_conv_result  in  DATA_WIDTH  conv_blk result (signed)
o_wr_en  out  1  output BRAM write strobe
o_wr_addr  out  AW  output BRAM write address
o_wr_data  out  DATA_WIDTH  output BRAM write data
o_busy  out  1  high in CLR/RUN
o_done  out  1  one-cycle completion pulse
o_err  out  1  sticky timeout flag, cleared by next accepted i_start
o_count  out  AW+1  results written this run

Behaviour:
- Reset (i_rst=0 at clock edge): state IDLE; o_blk_rst=1, o_go=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_err=0, o_count=0. Reset mid-run abandons the run with no done pulse.
- States: IDLE, CLR, RUN, DONE, ERR.
- IDLE: o_blk_rst=1, o_go=0. i_start=1 -> CLR; clear o_count, o_wr_addr, o_err and the timeout counter.
- CLR: o_blk_rst=1 for exactly CLR_CYCLES cycles, o_busy=1, then -> RUN.
- RUN: o_blk_rst=0, o_go=1, o_busy=1. Each cycle with i_en=1 -> next cycle o_wr_en=1, o_wr_data=i_conv_result, o_wr_addr=current index (registered, latency 1). Index and o_count then increment. Back-to-back i_en is supported at 1 result per cycle.
- The capture that makes o_count reach N_RES moves to DONE in the same edge. o_go drops the cycle after the last capture. The final write still appears in that cycle.
- DONE: o_done=1 for one cycle, o_busy=0, o_blk_rst=1 -> IDLE. i_en in DONE or IDLE is ignored (no write, no count).
- Timeout: in RUN a counter increments each cycle without i_en and clears on i_en. Reaching TIMEOUT -> ERR. ERR: o_err=1, o_go=0, o_blk_rst=1, one cycle -> IDLE. o_err holds until the next accepted start.
- i_abort=1 in CLR/RUN -> IDLE next cycle. No done, no err. A pending registered write still completes. i_abort has priority over i_en-completion and timeout in the same cycle.
- i_start while busy or in DONE/ERR: ignored. i_start and i_abort together in IDLE: start wins.
- o_wr_addr never exceeds N_RES-1. o_count saturates at N_RES.

Test Plan:
- Defaults (MAXPOOL=1, N_RES=4): i_start, then 4 i_en pulses with data 10,-3,7,0x7FFF_FFFF_FFFF -> writes to addr 0..3 with exact data, one cycle after each i_en. o_done is a single pulse; o_count=4.
- MAXPOOL=0 (N_RES=16): 16 back-to-back i_en -> 16 consecutive writes, addr 0..15, o_go low after the 16th. A 17th i_en produces no write.
- Reset timing: i_start -> o_blk_rst high for exactly 2 cycles, then o_go=1. Assert i_rst=0 after 2 results -> all outputs at reset values next cycle, no o_done.
- Timeout: TIMEOUT=8, start, 1 i_en, then silence -> ERR after 8 idle cycles. o_err=1 stays set until the next i_start; o_done never pulses.
- Abort: i_abort on the same cycle as the 4th i_en -> write of result 4 occurs, state IDLE, o_done=0. i_start during RUN is ignored (o_count unaffected).

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - run controller for one conv_blk layer pass
//
// Purpose: on a start request, holds conv_blk in reset for CLR_CYCLES, raises
// go, and writes every conv_blk result to the output feature-map BRAM at
// sequential addresses. After N_RES results it pulses done. If no result
// arrives for TIMEOUT cycles while running, it raises a sticky error.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_start, i_abort      run request (IDLE only), abandon current run
//   o_blk_rst, o_go       conv_blk reset (active-high) and go
//   i_en, i_conv_result   conv_blk result valid and signed data
//   o_wr_en/addr/data     output BRAM write port (1-cycle registered)
//   o_busy, o_done, o_err busy in CLR/RUN, done pulse, sticky timeout flag
//   o_count               results written this run (saturates at N_RES)
module conv_seq_ctrl #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 6,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1,
  parameter int MAXPOOL     = 1,
  parameter int DATA_WIDTH  = 48,
  parameter int CLR_CYCLES  = 2,
  parameter int TIMEOUT     = 1024,
  localparam int OUT_SIZE   = ((FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE) + 1,
  localparam int N_RES      = (MAXPOOL != 0) ? (OUT_SIZE / 2) * (OUT_SIZE / 2)
                                             : OUT_SIZE * OUT_SIZE,
  localparam int AW         = (N_RES > 1) ? $clog2(N_RES) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_blk_rst,
  output logic                  o_go,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_conv_result,
  output logic                  o_wr_en,
  output logic [AW-1:0]         o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [AW:0]           o_count
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [AW:0]   RES_LAST = (AW + 1)'(N_RES - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] clr_cnt;
  logic [TW-1:0] tmo_cnt;

  // The capture that fills the map and the last silent cycle before timeout
  logic last_capture;
  logic tmo_last;

  assign last_capture = i_en && (o_count == RES_LAST);
  assign tmo_last     = !i_en && (tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    o_blk_rst  = 1'b1;
    o_go       = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) next_state = S_CLR;
      end
      S_CLR: begin
        o_busy = 1'b1;
        if (i_abort)                 next_state = S_IDLE;
        else if (clr_cnt == CLR_LAST) next_state = S_RUN;
      end
      S_RUN: begin
        o_blk_rst = 1'b0;
        o_go      = 1'b1;
        o_busy    = 1'b1;
        // abort outranks both completion and timeout
        if (i_abort)           next_state = S_IDLE;
        else if (last_capture) next_state = S_DONE;
        else if (tmo_last)     next_state = S_ERR;
      end
      S_DONE: begin
        o_done     = 1'b1;
        next_state = S_IDLE;
      end
      S_ERR: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: counters, sticky error and the registered BRAM write port
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      clr_cnt   <= '0;
      tmo_cnt   <= '0;
      o_count   <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_err     <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            clr_cnt   <= '0;
            tmo_cnt   <= '0;
            o_count   <= '0;
            o_wr_addr <= '0;
            o_err     <= 1'b0;
          end
        end
        S_CLR: begin
          clr_cnt <= clr_cnt + 1'b1;
        end
        S_RUN: begin
          // a capture still lands even when aborted in the same cycle
          if (i_en) begin
            tmo_cnt   <= '0;
            o_wr_en   <= 1'b1;
            o_wr_data <= i_conv_result;
            o_wr_addr <= o_count[AW-1:0];
            o_count   <= o_count + 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          if (!i_abort && tmo_last) o_err <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - bench for conv_seq_ctrl against a run-level reference model
module tb_conv_seq_ctrl;

  localparam int DW   = 48;
  localparam int TMO  = 8;
  localparam int CLR  = 2;
  localparam int OUTS = ((6 - 3 + 0) / 1) + 1;
  localparam int NA   = (OUTS / 2) * (OUTS / 2);
  localparam int NB   = OUTS * OUTS;

  localparam int P_IDLE = 0;
  localparam int P_CLR  = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;
  localparam int P_ERR  = 4;

  logic clk;
  logic rst_n [2];
  logic start [2];
  logic abort [2];
  logic en    [2];
  logic [DW-1:0] din [2];
  logic blk_rst [2];
  logic go      [2];
  logic wr_en   [2];
  logic busy    [2];
  logic done    [2];
  logic err     [2];
  logic [DW-1:0] wdata [2];
  logic [3:0] addr [2];
  logic [4:0] cnt  [2];
  logic [1:0] addr_a;
  logic [2:0] cnt_a;

  int tests = 0;
  int fails = 0;

  int m_ph [2];
  int m_clr [2];
  int m_quiet [2];
  int m_got [2];
  int m_addr [2];
  bit m_err [2];
  bit m_wr [2];
  logic [DW-1:0] m_data [2];
  int n_res [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  conv_seq_ctrl #(.TIMEOUT(TMO)) dut_a (
    .i_clk(clk), .i_rst(rst_n[0]), .i_start(start[0]), .i_abort(abort[0]),
    .o_blk_rst(blk_rst[0]), .o_go(go[0]), .i_en(en[0]), .i_conv_result(din[0]),
    .o_wr_en(wr_en[0]), .o_wr_addr(addr_a), .o_wr_data(wdata[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]), .o_count(cnt_a)
  );
  assign addr[0] = {2'b00, addr_a};
  assign cnt[0]  = {2'b00, cnt_a};

  conv_seq_ctrl #(.MAXPOOL(0), .TIMEOUT(TMO)) dut_b (
    .i_clk(clk), .i_rst(rst_n[1]), .i_start(start[1]), .i_abort(abort[1]),
    .o_blk_rst(blk_rst[1]), .o_go(go[1]), .i_en(en[1]), .i_conv_result(din[1]),
    .o_wr_en(wr_en[1]), .o_wr_addr(addr[1]), .o_wr_data(wdata[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]), .o_count(cnt[1])
  );

  function automatic logic [DW-1:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Run-level model: a run clears for CLR cycles, then accepts results in
  // order until n_res are in, an abort arrives, or TMO silent cycles pass.
  task automatic model(input int d, input bit r, input bit s, input bit a,
                       input bit e, input logic [DW-1:0] x);
    if (!r) begin
      m_ph[d] = P_IDLE; m_got[d] = 0; m_err[d] = 0; m_wr[d] = 0;
      m_addr[d] = 0; m_data[d] = '0;
      return;
    end
    m_wr[d] = 0;
    case (m_ph[d])
      P_IDLE: if (s) begin
        m_ph[d] = P_CLR; m_clr[d] = CLR; m_got[d] = 0; m_addr[d] = 0;
        m_err[d] = 0; m_quiet[d] = 0;
      end
      P_CLR: begin
        m_clr[d]--;
        if (a) m_ph[d] = P_IDLE;
        else if (m_clr[d] == 0) m_ph[d] = P_RUN;
      end
      P_RUN: begin
        if (e) begin
          m_wr[d] = 1; m_data[d] = x; m_addr[d] = m_got[d];
          m_got[d]++; m_quiet[d] = 0;
        end else begin
          m_quiet[d]++;
        end
        if (a) m_ph[d] = P_IDLE;
        else if (m_got[d] == n_res[d]) m_ph[d] = P_DONE;
        else if (m_quiet[d] == TMO) begin
          m_ph[d] = P_ERR; m_err[d] = 1;
        end
      end
      default: m_ph[d] = P_IDLE;
    endcase
  endtask

  task automatic check(input int d);
    logic [5:0] got_s;
    logic [5:0] exp_s;
    got_s = {blk_rst[d], go[d], busy[d], done[d], err[d], wr_en[d]};
    exp_s = {m_ph[d] != P_RUN, m_ph[d] == P_RUN,
             m_ph[d] == P_CLR || m_ph[d] == P_RUN, m_ph[d] == P_DONE,
             m_err[d], m_wr[d]};
    tests++;
    assert (got_s === exp_s) else begin
      fails++;
      $error("FAIL status[%0d] rst/go/busy/done/err/wr got %b exp %b", d, got_s, exp_s);
    end
    tests++;
    assert (cnt[d] === 5'(m_got[d])) else begin
      fails++;
      $error("FAIL count[%0d] got %0d exp %0d", d, cnt[d], m_got[d]);
    end
    tests++;
    assert (addr[d] === 4'(m_addr[d])) else begin
      fails++;
      $error("FAIL addr[%0d] got %0d exp %0d", d, addr[d], m_addr[d]);
    end
    if (m_wr[d]) begin
      tests++;
      assert (wdata[d] === m_data[d]) else begin
        fails++;
        $error("FAIL data[%0d] got %h exp %h", d, wdata[d], m_data[d]);
      end
    end
  endtask

  // One clock: drive DUT d (d<0 resets both), advance models, check both
  task automatic step(input int d, input bit s, input bit a, input bit e,
                      input logic [DW-1:0] x, input bit r = 1'b1);
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = (d < 0) ? 1'b0 : ((k == d) ? r : 1'b1);
      start[k] = (k == d) && s;
      abort[k] = (k == d) && a;
      en[k]    = (k == d) && e;
      din[k]   = (k == d) ? x : '0;
      model(k, rst_n[k], start[k], abort[k], en[k], din[k]);
    end
    @(posedge clk);
    #1;
    check(0);
    check(1);
  endtask

  initial begin
    n_res[0] = NA;
    n_res[1] = NB;

    step(-1, 0, 0, 0, '0);
    step(-1, 0, 0, 0, '0);
    for (int d = 0; d < 2; d++) begin
      tests++;
      assert (wdata[d] === '0) else begin
        fails++;
        $error("FAIL reset_data[%0d] got %h exp 0", d, wdata[d]);
      end
    end

    // four results with gaps; a stray start mid-run; i_en after done ignored
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 48'd10);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 48'hFFFF_FFFF_FFFD);
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 1, 48'd7);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 48'h7FFF_FFFF_FFFF);
    step(0, 0, 0, 1, 48'd99);
    step(0, 0, 0, 1, 48'd98);
    step(0, 0, 0, 0, '0);

    // sixteen back-to-back results, then a seventeenth that must not write
    step(1, 1, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 17; i++) step(1, 0, 0, 1, rnd48());
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);

    // reset after two results
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, rnd48());
    step(0, 0, 0, 1, rnd48());
    step(0, 0, 0, 0, '0, 1'b0);
    step(0, 0, 0, 0, '0);

    // timeout, sticky error, cleared by next start (start+abort: start wins)
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, rnd48());
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, '0);
    step(0, 1, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    // abort together with the final result
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, rnd48());
    step(0, 0, 1, 1, rnd48());
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    // abort during the clear phase
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 0, '0);
    step(1, 0, 0, 0, '0);

    // randomized runs: random gaps (some long enough to time out), stray
    // starts, and occasional aborts
    for (int it = 0; it < 10; it++) begin
      int d;
      d = it % 2;
      step(d, 1, 0, 0, '0);
      for (int k = 0; k < 60 && m_ph[d] != P_IDLE; k++) begin
        int g;
        g = ($urandom_range(0, 12) == 0) ? 9 : int'($urandom_range(0, 3));
        for (int j = 0; j < g && m_ph[d] != P_IDLE; j++)
          step(d, $urandom_range(0, 7) == 0, 0, 0, rnd48());
        if (m_ph[d] != P_IDLE)
          step(d, 0, $urandom_range(0, 29) == 0, 1, rnd48());
      end
      step(d, 0, 0, 0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
